// File: rtl/adc_ram_readback_unpacker_if.sv
// Purpose : bundles the control, RAM read-port and sample-stream signals of the readback unpacker.
// Latency : none, wiring only.
// Backpressure: carries the iSampleReady / oSampleValid handshake and the oRDEN request strobe.
// Ports   : control  iStart, iPackMode, iNumWords, oBusy, oDone
//           RAM      oRAddr, oRDEN, iRData
//           stream   oSampleData, oSampleValid, iSampleReady
//           modport master = unpacker side, modport slave = RAM/HPS/control side.
interface adc_ram_readback_unpacker_if;
    logic         iStart;
    logic         iPackMode;
    logic [14:0]  iNumWords;
    logic [14:0]  oRAddr;
    logic         oRDEN;
    logic [127:0] iRData;
    logic [127:0] oSampleData;
    logic         oSampleValid;
    logic         iSampleReady;
    logic         oBusy;
    logic         oDone;

    modport master (
        input  iStart, iPackMode, iNumWords, iRData, iSampleReady,
        output oRAddr, oRDEN, oSampleData, oSampleValid, oBusy, oDone
    );

    modport slave (
        output iStart, iPackMode, iNumWords, iRData, iSampleReady,
        input  oRAddr, oRDEN, oSampleData, oSampleValid, oBusy, oDone
    );
endinterface

// File: rtl/adc_ram_readback_unpacker.sv
// Purpose : reads iNumWords words from the ADC capture RAM and streams them as raw words or as
//           unpacked 12-bit -> 16-bit timepoints (8 lanes x 16b) to the HPS transfer logic.
// Latency : first oSampleValid RD_LATENCY+2 clocks after the accepted iStart (ready held high).
// Backpressure: output register holds while valid & !ready; RAM reads are credit-limited so the
//           return FIFO never overflows.
// Ports   : adc_clkinp (clock), iStateReset (sync active-high reset), bus (interface, master).
module adc_ram_readback_unpacker #(
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        adc_clkinp,
    input  logic                        iStateReset,
    adc_ram_readback_unpacker_if.master bus
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] CREDIT_MAX = (AW+1)'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic                  pack_q;
    logic [14:0]           num_q;
    logic [16:0]           total_q;
    logic [16:0]           total_nxt;
    logic [16:0]           prod_cnt;
    logic [14:0]           rd_addr;
    logic [RD_LATENCY-1:0] rd_vld_sr;

    logic [127:0]          fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           fifo_cnt;
    // reads issued but not yet popped: in flight in the RAM plus sitting in the FIFO
    logic [AW:0]           used_cnt;

    logic [1:0]            phase;
    // upper 96 bits of the last popped word; its low 32 bits are never needed again
    logic [95:0]           residue;
    logic [95:0]           tp;
    logic [127:0]          lanes;
    logic [127:0]          out_dat;
    logic                  out_vld;

    logic                  start_acc;
    logic                  rden;
    logic                  push;
    logic                  pop;
    logic                  ld;
    logic                  avail;
    logic                  fifo_ne;
    logic                  last_rd;
    logic                  drained;
    logic [127:0]          fifo_head;

    assign start_acc = ((state == ST_IDLE) || (state == ST_DONE)) && bus.iStart;
    assign rden      = (state == ST_READ) && (used_cnt < CREDIT_MAX);
    assign push      = rd_vld_sr[RD_LATENCY-1];
    assign fifo_head = fifo_mem[rd_ptr];
    assign fifo_ne   = (fifo_cnt != '0);
    // phase 3 is served entirely from the residue, so it needs no FIFO word
    assign avail     = pack_q ? ((phase == 2'd3) || fifo_ne) : fifo_ne;
    assign ld        = ((state == ST_READ) || (state == ST_DRAIN)) && (prod_cnt != total_q)
                       && avail && (!out_vld || bus.iSampleReady);
    assign pop       = ld && (!pack_q || (phase != 2'd3));
    assign last_rd   = rden && (rd_addr == num_q - 15'd1);
    assign drained   = (prod_cnt == total_q) && (!out_vld || bus.iSampleReady);
    // packed: floor(N*4/3) timepoints; a trailing partial timepoint is dropped
    assign total_nxt = bus.iPackMode ? ({bus.iNumWords, 2'b00} / 17'd3) : {2'b00, bus.iNumWords};

    // timepoint selection over the bit stream {w2,w1,w0}, then 12b -> 16b lane expansion
    always_comb begin
        tp    = '0;
        lanes = '0;
        case (phase)
            2'd0:    tp = fifo_head[95:0];
            2'd1:    tp = {fifo_head[63:0], residue[95:64]};
            2'd2:    tp = {fifo_head[31:0], residue[95:32]};
            default: tp = residue;
        endcase
        for (int c = 0; c < 8; c++) begin
            lanes[16*c +: 16] = {4'b0000, tp[12*c +: 12]};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_acc) begin
                    state_nxt = (bus.iNumWords == 15'd0) ? ST_DONE : ST_READ;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_READ:  if (last_rd) state_nxt = ST_DRAIN;
            ST_DRAIN: if (drained) state_nxt = ST_DONE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge adc_clkinp) begin
        if (iStateReset) begin
            state     <= ST_IDLE;
            pack_q    <= 1'b0;
            num_q     <= '0;
            total_q   <= '0;
            prod_cnt  <= '0;
            rd_addr   <= '0;
            rd_vld_sr <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            used_cnt  <= '0;
            phase     <= '0;
            residue   <= '0;
            out_dat   <= '0;
            out_vld   <= 1'b0;
        end else begin
            state <= state_nxt;

            if (start_acc) begin
                pack_q   <= bus.iPackMode;
                num_q    <= bus.iNumWords;
                total_q  <= total_nxt;
                prod_cnt <= '0;
                rd_addr  <= '0;
                phase    <= '0;
                residue  <= '0;
            end else if (state == ST_DONE) begin
                phase   <= '0;
                residue <= '0;
            end else begin
                if (rden)            rd_addr  <= rd_addr + 15'd1;
                if (ld)              prod_cnt <= prod_cnt + 17'd1;
                if (ld && pack_q)    phase    <= phase + 2'd1;
                if (pop && pack_q)   residue  <= fifo_head[127:32];
            end

            rd_vld_sr[0] <= rden;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_vld_sr[i] <= rd_vld_sr[i-1];
            end

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase

            case ({rden, pop})
                2'b10:   used_cnt <= used_cnt + 1'b1;
                2'b01:   used_cnt <= used_cnt - 1'b1;
                default: used_cnt <= used_cnt;
            endcase

            if (ld) begin
                out_vld <= 1'b1;
                out_dat <= pack_q ? lanes : fifo_head;
            end else if (bus.iSampleReady) begin
                out_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge adc_clkinp) begin
        if (push) fifo_mem[wr_ptr] <= bus.iRData;
    end

    assign bus.oRAddr       = rd_addr;
    assign bus.oRDEN        = rden;
    assign bus.oSampleData  = out_dat;
    assign bus.oSampleValid = out_vld;
    // busy covers the accepting cycle itself, so a zero-length request is busy for one cycle
    assign bus.oBusy        = (start_acc && !iStateReset) || (state == ST_READ) || (state == ST_DRAIN);
    assign bus.oDone        = (state == ST_DONE);

endmodule

// File: tb/tb_adc_ram_readback_unpacker.sv
// Purpose : self-checking bench for adc_ram_readback_unpacker with a latency-accurate RAM model.
// Latency : n/a.
// Backpressure: sample ready is either held high or randomised per cycle.
module tb_adc_ram_readback_unpacker;
    localparam int RD_LATENCY = 2;
    localparam int FIFO_DEPTH = 4;

    logic adc_clkinp = 1'b0;
    logic iStateReset;
    adc_ram_readback_unpacker_if bus();

    adc_ram_readback_unpacker #(.RD_LATENCY(RD_LATENCY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .adc_clkinp (adc_clkinp),
        .iStateReset(iStateReset),
        .bus        (bus.master)
    );

    always #5 adc_clkinp = ~adc_clkinp;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [127:0] ram [64];
    logic [127:0] exp_q [$];

    int rd_cnt = 0, addr_base = 0, smp_cnt = 0, done_cnt = 0, busy_cnt = 0;
    int done_cyc = 0, last_hs_edge = 0, vld_rise_cyc = 0, start_cyc = 0;
    int rdy_mode = 0;
    int rb, sb, bb, d0;
    logic prev_stall = 1'b0, prev_vld = 1'b0;
    logic [127:0] prev_dat = '0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge adc_clkinp);
        #1;
    endtask

    task automatic do_start(input logic pack, input int n);
        addr_base     = rd_cnt;
        bus.iPackMode = pack;
        bus.iNumWords = 15'(n);
        bus.iStart    = 1'b1;
        @(posedge adc_clkinp);
        #1;
        start_cyc  = cyc;
        bus.iStart = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int d;
        d = done_cnt;
        for (int i = 0; i < budget && done_cnt == d; i++) tick(1);
        chk(tag, 128'(done_cnt - d), 128'd1);
    endtask

    task automatic push_raw(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(ram[i]);
    endtask

    // independent bit-stream model: timepoint k = S[96k+95:96k], lane c = {4'b0, ch c}
    task automatic push_packed(input int n);
        int total, b;
        logic [127:0] s, w;
        total = (n * 4) / 3;
        for (int k = 0; k < total; k++) begin
            s = '0;
            for (int c = 0; c < 8; c++) begin
                for (int j = 0; j < 12; j++) begin
                    b = 96*k + 12*c + j;
                    w = ram[b / 128];
                    s[16*c + j] = w[b % 128];
                end
            end
            exp_q.push_back(s);
        end
    endtask

    task automatic fill_channels();
        logic [575:0] st;
        st = '0;
        for (int k = 0; k < 6; k++)
            for (int c = 0; c < 8; c++)
                st[96*k + 12*c +: 12] = 12'(256*k + c);
        for (int w = 0; w < 4; w++) ram[w] = st[128*w +: 128];
    endtask

    task automatic push_channel_lanes(input int nk);
        logic [127:0] s;
        for (int k = 0; k < nk; k++) begin
            for (int c = 0; c < 8; c++) s[16*c +: 16] = 16'(256*k + c);
            exp_q.push_back(s);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rden"},  128'(bus.oRDEN), 128'd0);
        chk({tag, "_raddr"}, 128'(bus.oRAddr), 128'd0);
        chk({tag, "_vld"},   128'(bus.oSampleValid), 128'd0);
        chk({tag, "_dat"},   bus.oSampleData, 128'd0);
        chk({tag, "_busy"},  128'(bus.oBusy), 128'd0);
        chk({tag, "_done"},  128'(bus.oDone), 128'd0);
    endtask

    initial forever begin
        @(posedge adc_clkinp);
        cyc++;
    end

    // RAM read port: data appears RD_LATENCY clocks after the request cycle
    initial begin
        logic        pv [RD_LATENCY+1];
        logic [14:0] pa [RD_LATENCY+1];
        for (int i = 0; i <= RD_LATENCY; i++) begin pv[i] = 1'b0; pa[i] = '0; end
        bus.iRData = '0;
        forever begin
            @(negedge adc_clkinp);
            for (int i = RD_LATENCY; i > 0; i--) begin pv[i] = pv[i-1]; pa[i] = pa[i-1]; end
            pv[0] = bus.oRDEN;
            pa[0] = bus.oRAddr;
            bus.iRData = pv[RD_LATENCY] ? ram[pa[RD_LATENCY][5:0]] : {4{32'hDEADBEEF}};
        end
    end

    initial begin
        bus.iSampleReady = 1'b1;
        forever begin
            @(posedge adc_clkinp);
            #1;
            bus.iSampleReady = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // monitor: addresses, stall stability, scoreboard pop, done/busy bookkeeping
    initial forever begin
        @(negedge adc_clkinp);
        if (bus.oRDEN) begin
            chk("raddr", 128'(bus.oRAddr), 128'(15'(rd_cnt - addr_base)));
            rd_cnt++;
        end
        if (prev_stall && !iStateReset) begin
            chk("stall_vld", 128'(bus.oSampleValid), 128'd1);
            chk("stall_dat", bus.oSampleData, prev_dat);
        end
        if (bus.oSampleValid && !prev_vld) vld_rise_cyc = cyc;
        if (bus.oSampleValid && bus.iSampleReady) begin
            if (exp_q.size() == 0) chk("sample_unexpected", 128'(exp_q.size()), 128'd1);
            else                   chk("sample", bus.oSampleData, exp_q.pop_front());
            smp_cnt++;
            last_hs_edge = cyc + 1;
        end
        prev_stall = bus.oSampleValid && !bus.iSampleReady;
        prev_dat   = bus.oSampleData;
        prev_vld   = bus.oSampleValid;
        if (bus.oDone) begin done_cnt++; done_cyc = cyc; end
        if (bus.oBusy) busy_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        iStateReset   = 1'b1;
        bus.iStart    = 1'b0;
        bus.iPackMode = 1'b0;
        bus.iNumWords = '0;
        for (int i = 0; i < 64; i++) ram[i] = {16{8'(i)}};
        tick(3);
        chk_outputs_zero("reset");
        iStateReset = 1'b0;
        tick(2);

        // raw, N=4: order, first-valid latency, done timing
        rb = rd_cnt; sb = smp_cnt;
        push_raw(4);
        do_start(1'b0, 4);
        wait_done(100, "raw_done_seen");
        chk("raw_latency", 128'(vld_rise_cyc - start_cyc), 128'(RD_LATENCY + 2));
        chk("raw_done_after_hs", 128'(done_cyc), 128'(last_hs_edge));
        chk("raw_samples", 128'(smp_cnt - sb), 128'd4);
        chk("raw_reads", 128'(rd_cnt - rb), 128'd4);
        chk("raw_q_empty", 128'(exp_q.size()), 128'd0);
        tick(2);

        // packed, N=3 and N=4 from channel values 0x100*k+c
        fill_channels();
        sb = smp_cnt;
        push_channel_lanes(4);
        do_start(1'b1, 3);
        wait_done(100, "pk3_done_seen");
        chk("pk3_samples", 128'(smp_cnt - sb), 128'd4);
        chk("pk3_q_empty", 128'(exp_q.size()), 128'd0);
        tick(2);
        sb = smp_cnt;
        push_channel_lanes(5);
        do_start(1'b1, 4);
        wait_done(100, "pk4_done_seen");
        chk("pk4_samples", 128'(smp_cnt - sb), 128'd5);
        chk("pk4_q_empty", 128'(exp_q.size()), 128'd0);
        tick(2);

        // backpressure, raw N=16 then packed N=16, random ready
        rdy_mode = 1;
        for (int i = 0; i < 64; i++) ram[i] = {$urandom, $urandom, $urandom, $urandom};
        rb = rd_cnt; sb = smp_cnt;
        push_raw(16);
        do_start(1'b0, 16);
        wait_done(2000, "bp_raw_done_seen");
        chk("bp_raw_samples", 128'(smp_cnt - sb), 128'd16);
        chk("bp_raw_reads", 128'(rd_cnt - rb), 128'd16);
        chk("bp_raw_q_empty", 128'(exp_q.size()), 128'd0);
        tick(2);
        sb = smp_cnt;
        push_packed(16);
        do_start(1'b1, 16);
        wait_done(2000, "bp_pk_done_seen");
        chk("bp_pk_samples", 128'(smp_cnt - sb), 128'd21);
        chk("bp_pk_q_empty", 128'(exp_q.size()), 128'd0);
        rdy_mode = 0;
        tick(3);

        // N=0: no reads, done the next clock, busy exactly one cycle
        rb = rd_cnt; bb = busy_cnt;
        do_start(1'b0, 0);
        wait_done(20, "n0_done_seen");
        chk("n0_done_cycle", 128'(done_cyc), 128'(start_cyc));
        chk("n0_reads", 128'(rd_cnt - rb), 128'd0);
        chk("n0_busy_cycles", 128'(busy_cnt - bb), 128'd1);
        tick(2);

        // reset mid-READ at word 5 of 10, then restart from address 0
        for (int i = 0; i < 64; i++) ram[i] = {4{32'hC0DE0000 + 32'(i)}};
        rb = rd_cnt;
        push_raw(10);
        do_start(1'b0, 10);
        for (int i = 0; i < 100 && (rd_cnt - rb) < 5; i++) tick(1);
        chk("rst_reached_word5", 128'((rd_cnt - rb) >= 5), 128'd1);
        iStateReset = 1'b1;
        tick(1);
        chk_outputs_zero("midrst");
        exp_q.delete();
        d0 = done_cnt;
        iStateReset = 1'b0;
        tick(10);
        chk("midrst_no_done", 128'(done_cnt - d0), 128'd0);
        rb = rd_cnt; sb = smp_cnt;
        push_raw(4);
        do_start(1'b0, 4);
        wait_done(100, "restart_done_seen");
        chk("restart_samples", 128'(smp_cnt - sb), 128'd4);
        chk("restart_reads", 128'(rd_cnt - rb), 128'd4);
        tick(2);

        // iStart while busy is ignored
        rb = rd_cnt; sb = smp_cnt; d0 = done_cnt;
        push_raw(8);
        do_start(1'b0, 8);
        tick(3);
        bus.iPackMode = 1'b1;
        bus.iNumWords = 15'd3;
        bus.iStart    = 1'b1;
        tick(1);
        bus.iStart    = 1'b0;
        wait_done(200, "busy_start_done_seen");
        tick(5);
        chk("busy_start_samples", 128'(smp_cnt - sb), 128'd8);
        chk("busy_start_reads", 128'(rd_cnt - rb), 128'd8);
        chk("busy_start_one_done", 128'(done_cnt - d0), 128'd1);
        chk("busy_start_q_empty", 128'(exp_q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
